// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text renderer.
// Contents:
//   CHAR_W / CHAR_H      glyph cell size in pixels (8 x 16)
//   PIPE_LATENCY         pixel-in to pixel_on latency in clock cycles
//   FONT_ADDR_W          font ROM address width ({char_code, glyph_row})
//   CHAR_ADDR_W          text buffer address width
//   UNDERLINE_ROW        first glyph row of the cursor underline
//   strobes_t            the three timing strobes carried down the pipeline
//   font_address()       builds a font ROM address from code and glyph row
package text_pkg;

    localparam int CHAR_W       = 8;
    localparam int CHAR_H       = 16;
    localparam int PIPE_LATENCY = 3;
    localparam int FONT_ADDR_W  = 11;
    localparam int CHAR_ADDR_W  = 12;
    localparam int GROW_W       = $clog2(CHAR_H);
    localparam int GCOL_W       = $clog2(CHAR_W);

    localparam logic [GROW_W-1:0] UNDERLINE_ROW = 4'd14;

    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } strobes_t;

    function automatic logic [FONT_ADDR_W-1:0] font_address(
        input logic [6:0]        code,
        input logic [GROW_W-1:0] glyph_row
    );
        return {code, glyph_row};
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer.
// Counts rising edges of vsync (one per frame); every BLINK_FRAMES frames
// the counter wraps to 0 and blink_phase toggles.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   vsync_in      vertical sync strobe from the timing generator
//   blink_phase   current blink half-period (1 = underline visible)
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic blink_phase
);

    // Width kept at least 1 so BLINK_FRAMES = 1 still elaborates.
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_prev_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             blink_phase_reg;
    logic             vsync_rise;

    assign vsync_rise  = vsync_in & ~vsync_prev_reg;
    assign blink_phase = blink_phase_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_reg  <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (vsync_rise) begin
                if (frame_cnt_reg == LAST_FRAME) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/text_renderer.sv
// Character-cell text renderer: turns timing-generator pixel coordinates
// into a foreground pixel using an external text buffer and font ROM, both
// with one cycle of registered read latency. A blinking underline is drawn
// on the bottom glyph rows of the cursor cell.
// Pipeline (3 cycles, no bubbles):
//   stage 0  char_addr from the incoming coordinates (combinational)
//   stage 1  glyph col/row, cell coords, strobes; font_addr from char_code
//   stage 2  glyph col/row, cursor hit, strobes; font_data arrives here
//   stage 3  pixel_on and delayed strobes
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   pixel_x, pixel_y                     current pixel from timing generator
//   video_on_in, hsync_in, vsync_in      timing strobes aligned with pixel_x/y
//   cursor_col, cursor_row               cursor cell position
//   char_addr / char_code                text buffer read port
//   font_addr / font_data                font ROM read port (bit 7 = leftmost)
//   pixel_on                             registered foreground pixel
//   video_on_out, hsync_out, vsync_out   strobes aligned with pixel_on
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   video_on_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [6:0]             cursor_col,
    input  logic [4:0]             cursor_row,
    output logic [CHAR_ADDR_W-1:0] char_addr,
    input  logic [6:0]             char_code,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [CHAR_W-1:0]      font_data,
    output logic                   pixel_on,
    output logic                   video_on_out,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    // The whole screen must be addressable by the text buffer; larger
    // geometries would silently alias rows.
    if (COLS * ROWS > (1 << CHAR_ADDR_W)) begin : g_bad_geometry
        $error("text_renderer: COLS*ROWS exceeds the text buffer address space");
    end

    // ---------------- stage 0 ----------------
    logic [6:0]  cell_col;
    logic [4:0]  cell_row;
    logic [31:0] addr_full;
    strobes_t    strb_in;

    assign cell_col  = pixel_x[9:3];
    assign cell_row  = pixel_y[8:4];
    assign addr_full = 32'(cell_row) * 32'(COLS) + 32'(cell_col);
    // Off-screen cells simply wrap inside the 12-bit address space.
    assign char_addr = addr_full[CHAR_ADDR_W-1:0];
    assign strb_in   = {video_on_in, hsync_in, vsync_in};

    logic unused_bits;
    assign unused_bits = ^{pixel_y[9], addr_full[31:CHAR_ADDR_W]};

    // ---------------- stage 1 ----------------
    logic [GCOL_W-1:0] s1_gcol_reg;
    logic [GROW_W-1:0] s1_grow_reg;
    logic [6:0]        s1_cell_col_reg;
    logic [4:0]        s1_cell_row_reg;
    strobes_t          s1_strb_reg;
    logic              cursor_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_gcol_reg     <= '0;
            s1_grow_reg     <= '0;
            s1_cell_col_reg <= '0;
            s1_cell_row_reg <= '0;
            s1_strb_reg     <= '0;
        end else begin
            s1_gcol_reg     <= pixel_x[2:0];
            s1_grow_reg     <= pixel_y[3:0];
            s1_cell_col_reg <= cell_col;
            s1_cell_row_reg <= cell_row;
            s1_strb_reg     <= strb_in;
        end
    end

    // char_code for this pixel is valid now, so the ROM lookup starts here.
    assign font_addr  = font_address(char_code, s1_grow_reg);
    assign cursor_hit = (s1_cell_col_reg == cursor_col) &&
                        (s1_cell_row_reg == cursor_row);

    // ---------------- stage 2 ----------------
    logic [GCOL_W-1:0] s2_gcol_reg;
    logic [GROW_W-1:0] s2_grow_reg;
    logic              s2_hit_reg;
    strobes_t          s2_strb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_gcol_reg <= '0;
            s2_grow_reg <= '0;
            s2_hit_reg  <= 1'b0;
            s2_strb_reg <= '0;
        end else begin
            s2_gcol_reg <= s1_gcol_reg;
            s2_grow_reg <= s1_grow_reg;
            s2_hit_reg  <= cursor_hit;
            s2_strb_reg <= s1_strb_reg;
        end
    end

    // Reverse the ROM byte so index 0 is the leftmost pixel of the glyph.
    logic [CHAR_W-1:0] glyph_lr;
    for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_glyph_order
        assign glyph_lr[gi] = font_data[CHAR_W-1-gi];
    end

    logic blink_phase;
    logic underline;
    logic pixel_next;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .blink_phase(blink_phase)
    );

    assign underline  = s2_hit_reg & blink_phase & (s2_grow_reg >= UNDERLINE_ROW);
    // XOR so the underline inverts rather than overwrites the glyph.
    assign pixel_next = s2_strb_reg.video_on & (glyph_lr[s2_gcol_reg] ^ underline);

    // ---------------- stage 3 ----------------
    logic     pixel_on_reg;
    strobes_t s3_strb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on_reg <= 1'b0;
            s3_strb_reg  <= '0;
        end else begin
            pixel_on_reg <= pixel_next;
            s3_strb_reg  <= s2_strb_reg;
        end
    end

    assign pixel_on     = pixel_on_reg;
    assign video_on_out = s3_strb_reg.video_on;
    assign hsync_out    = s3_strb_reg.hsync;
    assign vsync_out    = s3_strb_reg.vsync;

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer. Text buffer and font ROM are
// modelled as arrays with one cycle of read latency; expected pixels come
// from a reference function that renders each pixel directly from the
// screen rules (cell lookup, glyph bit, cursor underline, blink phase).
module tb_text_renderer;
    import text_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int BF   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on_in, hsync_in, vsync_in;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] char_addr;
    logic [6:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        pixel_on, video_on_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    text_renderer #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .char_addr(char_addr), .char_code(char_code),
        .font_addr(font_addr), .font_data(font_data),
        .pixel_on(pixel_on), .video_on_out(video_on_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    logic [6:0] text_mem [0:4095];
    logic [7:0] font_mem [0:2047];

    always @(posedge clk) begin
        char_code <= text_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct packed {
        logic pix;
        logic von;
        logic hs;
        logic vs;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_out;
    int         vectors = 0;
    int         miscompares = 0;
    int         rises = 0;
    logic       vs_prev = 1'b0;

    // Renders one pixel from the screen rules.
    function automatic logic model_pixel(input int x, input int y, input logic von);
        int         col, row, addr, gr;
        logic [6:0] code;
        logic [7:0] bits;
        logic       glyph, phase, ul;
        col   = x / 8;
        row   = (y / 16) % 32;
        addr  = (row * COLS + col) % 4096;
        code  = text_mem[addr];
        gr    = y % 16;
        bits  = font_mem[int'(code) * 16 + gr];
        glyph = bits[7 - (x % 8)];
        phase = ((rises / BF) % 2) == 1;
        ul    = (col == int'(cursor_col)) && (row == int'(cursor_row)) && phase && (gr >= 14);
        return von & (glyph ^ ul);
    endfunction

    // One clock: sample outputs after the edge, compare with the model
    // entry from PIPE_LATENCY cycles ago, then drive the next pixel.
    task automatic cycle(input int x, input int y, input logic von,
                         input logic hs, input logic vs, input logic r = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        last_out = {pixel_on, video_on_out, hsync_out, vsync_out};
        if (exp_q.size() >= PIPE_LATENCY) begin
            e = exp_q.pop_front();
            vectors++;
            if (last_out !== e) begin
                miscompares++;
                $display("FAIL pipeline_out t=%0t: {pix,von,hs,vs} got %b required %b",
                         $time, last_out, e);
            end
        end
        rst         = r;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        video_on_in = von;
        hsync_in    = hs;
        vsync_in    = vs;
        if (r) begin
            exp_q.delete();
            for (int k = 0; k < PIPE_LATENCY; k++) exp_q.push_back('0);
            rises   = 0;
            vs_prev = 1'b0;
        end else begin
            if (vs && !vs_prev) rises++;
            vs_prev = vs;
            e.pix = model_pixel(x, y, von);
            e.von = von;
            e.hs  = hs;
            e.vs  = vs;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) cycle(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (last_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 0000", last_out);
        end
        vectors++;
        if ({dut.u_blink.blink_phase_reg, dut.u_blink.frame_cnt_reg, dut.u_blink.vsync_prev_reg} !== '0) begin
            miscompares++;
            $display("FAIL reset_blink: phase=%b cnt=%0d prev=%b required all 0",
                     dut.u_blink.blink_phase_reg, dut.u_blink.frame_cnt_reg, dut.u_blink.vsync_prev_reg);
        end
        cycle(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_glyph_sweep();
        logic [7:0] pat;
        pat = 8'b00011000;
        flush();
        text_mem[0] = 7'd65;
        font_mem[65 * 16 + 3] = 8'h18;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) cycle(i, 3, 1'b1, 1'b0, 1'b0);
            else       cycle(0, 0, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                #1;
                vectors++;
                if (font_addr !== 11'd1043) begin
                    miscompares++;
                    $display("FAIL glyph_font_addr: got %0d required 1043", font_addr);
                end
            end
            if (i >= 3) begin
                vectors++;
                if (last_out.pix !== pat[7 - (i - 3)]) begin
                    miscompares++;
                    $display("FAIL glyph_sweep x=%0d: got %b required %b", i - 3, last_out.pix, pat[7 - (i - 3)]);
                end
            end
        end
    endtask

    task automatic test_last_cell();
        flush();
        cycle(639, 479, 1'b1, 1'b1, 1'b1);
        #1;
        vectors++;
        if (char_addr !== 12'd2399) begin
            miscompares++;
            $display("FAIL last_cell_addr: got %0d required 2399", char_addr);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (last_out[2:0] !== ((i == 3) ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL strobe_latency cycle %0d: got %b required %b",
                         i, last_out[2:0], (i == 3) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_video_blank();
        logic [7:0] vpat;
        vpat = 8'b10010110;
        flush();
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'hFF;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) cycle($urandom_range(0, 1023), $urandom_range(0, 495), vpat[i], 1'b0, 1'b0);
            else       cycle(0, 0, 1'b0, 1'b0, 1'b0);
            if (i >= 3) begin
                vectors++;
                if (last_out.pix !== vpat[i - 3]) begin
                    miscompares++;
                    $display("FAIL video_mask idx=%0d: got %b required %b", i - 3, last_out.pix, vpat[i - 3]);
                end
            end
        end
    endtask

    task automatic test_cursor_blink();
        int xs, ys;
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        flush();
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        text_mem[0] = 7'd32;
        text_mem[1] = 7'd32;
        cursor_col  = 7'd0;
        cursor_row  = 5'd0;
        cycle(0, 0, 1'b0, 1'b0, 1'b1);
        cycle(0, 0, 1'b0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dut.u_blink.blink_phase_reg !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_phase: got %b required 1", dut.u_blink.blink_phase_reg);
        end
        for (int i = 0; i < 35; i++) begin
            if (i < 32) begin
                xs = (i < 24) ? (i % 8) : 8 + (i % 8);
                ys = (i < 8) ? 14 : (i < 16) ? 15 : (i < 24) ? 13 : 14;
                cycle(xs, ys, 1'b1, 1'b0, 1'b0);
            end else begin
                cycle(0, 0, 1'b0, 1'b0, 1'b0);
            end
            if (i >= 3) begin
                vectors++;
                if (last_out.pix !== ((i - 3) < 16)) begin
                    miscompares++;
                    $display("FAIL cursor_underline idx=%0d: got %b required %b",
                             i - 3, last_out.pix, ((i - 3) < 16));
                end
            end
        end
    endtask

    task automatic test_reset_mid_line();
        flush();
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'hFF;
        cursor_col = 7'd127;
        cursor_row = 5'd31;
        cycle(0, 0, 1'b0, 1'b0, 1'b1);
        cycle(0, 0, 1'b0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dut.u_blink.frame_cnt_reg !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_count_pre: got %0d required 1", dut.u_blink.frame_cnt_reg);
        end
        for (int i = 0; i < 3; i++) cycle(8 + i, 100, 1'b1, 1'b1, 1'b0);
        cycle(11, 100, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            cycle(11 + j, 100, 1'b1, 1'b1, 1'b0);
            vectors++;
            if (last_out.pix !== (j >= 4)) begin
                miscompares++;
                $display("FAIL reset_flush cycle %0d: got %b required %b", j, last_out.pix, (j >= 4));
            end
            if (j == 1) begin
                vectors++;
                if ({dut.u_blink.blink_phase_reg, dut.u_blink.frame_cnt_reg} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_blink_clear: phase=%b cnt=%0d required 0",
                             dut.u_blink.blink_phase_reg, dut.u_blink.frame_cnt_reg);
                end
            end
        end
    endtask

    // Random lines: visible runs (often aimed at the cursor cell) separated
    // by blanking, where the cursor moves and vsync pulses advance the blink.
    task automatic test_back_to_back();
        int x, y;
        flush();
        for (int i = 0; i < 4096; i++) text_mem[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        cursor_col = 7'($urandom_range(0, COLS - 1));
        cursor_row = 5'($urandom_range(0, ROWS - 1));
        for (int line = 0; line < 20; line++) begin
            for (int p = 0; p < 24; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = int'(cursor_col) * 8 + $urandom_range(0, 7);
                    y = int'(cursor_row) * 16 + $urandom_range(12, 15);
                end else begin
                    x = $urandom_range(0, 1023);
                    y = $urandom_range(0, 1023);
                end
                cycle(x, y, ($urandom_range(0, 7) != 0), 1'($urandom), 1'b0);
            end
            for (int k = 0; k < 7; k++) begin
                cycle($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0,
                      1'($urandom), ((line % 2 == 1) && (k == 2 || k == 3)));
                if (k == 1) begin
                    cursor_col = 7'($urandom_range(0, COLS - 1));
                    cursor_row = 5'($urandom_range(0, ROWS - 1));
                end
            end
        end
        flush();
    endtask

    initial begin
        rst = 1'b1;
        pixel_x = '0; pixel_y = '0;
        video_on_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        cursor_col = 7'd127;
        cursor_row = 5'd31;
        for (int i = 0; i < 4096; i++) text_mem[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);

        test_reset();
        test_glyph_sweep();
        test_last_cell();
        test_video_blank();
        test_cursor_blink();
        test_reset_mid_line();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameter COLS, default 80, text columns per screen.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter BLINK_FRAMES, default 30, frames per cursor blink half-period.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pixel_x  in  10  current pixel column from the timing generator.
REQ-007 pixel_y  in  10  current pixel row from the timing generator.
REQ-008 video_on_in / hsync_in / vsync_in  in  1 each  timing-generator strobes, aligned with pixel_x/pixel_y.
REQ-009 cursor_col  in  7  cursor cell column.
REQ-010 cursor_row  in  5  cursor cell row.
REQ-011 char_addr  out  12  text-buffer read address, row*COLS+col.
REQ-012 char_code  in  7  ASCII code from the text buffer; valid 1 cycle after char_addr.
REQ-013 font_addr  out  11  font ROM address {char_code, glyph_row[3:0]}.
REQ-014 font_data  in  8  glyph row from the font ROM; valid 1 cycle after font_addr; bit 7 is the leftmost pixel.
REQ-015 pixel_on  out  1  registered foreground pixel.
REQ-016 video_on_out / hsync_out / vsync_out  out  1 each  input strobes delayed to align with pixel_on.

Function
REQ-017 Cell column SHALL be pixel_x[9:3], cell row pixel_y[8:4], glyph column pixel_x[2:0], glyph row pixel_y[3:0].
REQ-018 Stage 0 (combinational from inputs): char_addr = cell_row*COLS + cell_col, truncated to 12 bits.
REQ-019 Stage 1 register: glyph column, glyph row, cell coordinates, strobes; font_addr = {char_code, stage-1 glyph row}, driven combinationally.
REQ-020 Stage 2 register: glyph column, cursor-hit flag, strobes; font_data sampled here.
REQ-021 Stage 3 register: pixel_on = video_on_s2 & (font_data[7 - glyph_col] XOR underline), where underline = cursor_hit & blink_phase & (glyph_row >= 14).
REQ-022 End-to-end latency SHALL be exactly 3 cycles from pixel_x/pixel_y/strobes to pixel_on and the *_out strobes, for every input with no bubbles.
REQ-023 cursor_hit SHALL be set when cell_col==cursor_col and cell_row==cursor_row, sampled in stage 1.
REQ-024 When video_on is low at the input, pixel_on SHALL be 0 three cycles later regardless of font_data.
REQ-025 Blink timer: detect vsync_in rising edge (registered previous value); frame counter 0..BLINK_FRAMES-1; at wrap, counter goes to 0 and blink_phase toggles.
REQ-026 A cursor_col/cursor_row change SHALL take effect on the next pixel sampled, with no glitch on other cells.
REQ-027 Cell coordinates beyond COLS/ROWS SHALL still produce a truncated char_addr; pixel_on is masked only by video_on.

Reset
REQ-028 During rst, pixel_on, video_on_out, hsync_out, vsync_out, all pipeline registers, frame counter, blink_phase and the vsync edge register SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL flush the pipeline; after release, outputs SHALL be 0 for 3 cycles and then track the inputs.

Structure
REQ-030 Package text_pkg SHALL hold CHAR_W=8, CHAR_H=16, PIPE_LATENCY=3, FONT_ADDR_W=11, CHAR_ADDR_W=12 and the cursor underline start row (14).
REQ-031 Sub-module blink_timer (vsync edge detection, frame counter, blink_phase) SHALL be instantiated once.

Verification
REQ-032 Test 1. Buffer model returns 65 ('A') at address 0; ROM model gives row 3 = 00011000; sweep x=0..7 at y=3 with video_on=1. Required: font_addr=1043; pixel_on=0,0,0,1,1,0,0,0 starting cycle 3.
REQ-033 Test 2. Drive x=639, y=479. Required: char_addr=2399 in the same cycle; strobes on *_out exactly 3 cycles later.
REQ-034 Test 3. Drive video_on_in=0 with ROM returning 0xFF. Required: pixel_on=0 three cycles later.
REQ-035 Test 4. Use BLINK_FRAMES=2, cursor at (0,0) on a blank char (ROM 0x00), and pulse vsync twice. Required: blink_phase=1; y=14..15, x=0..7 give pixel_on=1; y=13 gives 0; cell (1,0) gives 0.
REQ-036 Test 5. Assert rst for one cycle mid-line with ROM 0xFF and video_on=1. Required: pixel_on=0 for the reset cycle plus 3 cycles, then 1; blink counter and phase cleared.
